// File: rtl/einstein_pkg.sv
// Shared types and helpers for the Einstein Z80 mode-2 interrupt controller.
package einstein_pkg;

  localparam int unsigned NCH_MAX = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    ACK    = 2'd2
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } lsb_t;

  // Index of the lowest set bit (highest priority), with a valid flag.
  function automatic lsb_t lowest_set(input logic [NCH_MAX-1:0] v);
    lsb_t r;
    r = '0;
    for (int i = NCH_MAX - 1; i >= 0; i--) begin
      if (v[i]) begin
        r.valid = 1'b1;
        r.idx   = IDX_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/einstein_irq_ctrl_sync.sv
// Per-channel 2-flop synchroniser for an active-low request plus falling-edge detector.
module irq_sync_edge (
  input  logic clk_sys,
  input  logic reset,
  input  logic irq_n,
  output logic s_n,
  output logic fall_c
);

  logic meta_n;
  logic prev_n;

  // Flops idle high so a released source never looks like an edge out of reset.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      meta_n <= 1'b1;
      s_n    <= 1'b1;
      prev_n <= 1'b1;
    end else begin
      meta_n <= irq_n;
      s_n    <= meta_n;
      prev_n <= s_n;
    end
  end

  assign fall_c = prev_n & ~s_n;

endmodule

// File: rtl/einstein_irq_ctrl.sv
// Z80 mode-2 vectored interrupt controller with IEI/IEO daisy chain.
// Optional in-service nesting is enabled by defining IRQ_NESTING_EN.
module einstein_irq_ctrl
  import einstein_pkg::*;
#(
  parameter int unsigned NCH      = 4,
  parameter logic [7:0]  VEC_BASE = 8'h00
) (
  input  logic           clk_sys,
  input  logic           reset,
  input  logic [NCH-1:0] irq_n,
  input  logic [NCH-1:0] mode,
  input  logic           inta_n,
  input  logic           reti,
  input  logic           iei,
  output logic           ieo,
  input  logic           mask_we,
  input  logic [NCH-1:0] mask_din,
  input  logic [NCH-1:0] pend_clr,
  output logic           int_n,
  output logic [7:0]     vector,
  output logic           vec_oe,
  output logic [NCH-1:0] mask_q,
  output logic [NCH-1:0] pending_q
);

  state_t         state;
  state_t         state_nxt;
  logic [NCH-1:0] s_n;
  logic [NCH-1:0] fall_c;
  logic [NCH-1:0] pend_hold_c;
  logic [NCH-1:0] pend_set_c;
  logic [NCH-1:0] pend_nxt_c;
  logic [NCH-1:0] elig_c;
  logic [NCH-1:0] req_c;
  logic [NCH-1:0] sel_bit_c;
  logic [NCH-1:0] ack_clr_c;
  lsb_t           sel_c;
  logic           ack_entry_c;
  logic           int_n_nxt_c;
  logic           vec_oe_nxt_c;
  logic           in_service_c;

  for (genvar g = 0; g < NCH; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk_sys (clk_sys),
      .reset   (reset),
      .irq_n   (irq_n[g]),
      .s_n     (s_n[g]),
      .fall_c  (fall_c[g])
    );
  end

`ifdef IRQ_NESTING_EN
  logic [NCH-1:0] isr;
  logic [NCH-1:0] isr_low_c;

  // Lowest in-service bit; subtracting one gives the strictly-higher-priority set
  // (all ones when nothing is in service).
  assign isr_low_c    = isr & (~isr + NCH'(1));
  assign elig_c       = isr_low_c - NCH'(1);
  assign in_service_c = |isr;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      isr <= '0;
    end else begin
      isr <= (isr & ~(reti ? isr_low_c : '0)) | (ack_entry_c ? sel_bit_c : '0);
    end
  end
`else
  logic unused_reti;

  assign unused_reti  = reti;
  assign elig_c       = '1;
  assign in_service_c = 1'b0;
`endif

  // Request view includes this cycle's edges so int_n follows the synchroniser by one flop.
  assign pend_hold_c = pending_q & ~pend_clr;
  assign pend_set_c  = (mode & (fall_c | pend_hold_c)) | (~mode & ~s_n);
  assign req_c       = pend_set_c & ~mask_q & elig_c;
  assign sel_c       = lowest_set(NCH_MAX'(req_c));
  assign sel_bit_c   = NCH'(1) << sel_c.idx;
  assign ack_entry_c = (state == ASSERT) && (state_nxt == ACK);
  assign ack_clr_c   = ack_entry_c ? (sel_bit_c & mode) : '0;
  // A fresh edge beats a same-cycle clear.
  assign pend_nxt_c  = (mode & (fall_c | (pend_hold_c & ~ack_clr_c))) | (~mode & ~s_n);

  assign ieo = iei & (state == IDLE) & ~in_service_c;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      int_n  <= 1'b1;
      vec_oe <= 1'b0;
    end else begin
      state  <= state_nxt;
      int_n  <= int_n_nxt_c;
      vec_oe <= vec_oe_nxt_c;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (sel_c.valid && iei && inta_n) state_nxt = ASSERT;
      end
      ASSERT: begin
        if (!sel_c.valid || !iei) state_nxt = IDLE;
        else if (!inta_n)         state_nxt = ACK;
      end
      ACK: begin
        if (inta_n) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    int_n_nxt_c  = 1'b1;
    vec_oe_nxt_c = 1'b0;
    if (state_nxt == ASSERT) int_n_nxt_c  = 1'b0;
    if (state_nxt == ACK)    vec_oe_nxt_c = 1'b1;
  end

  // Vector is frozen at acknowledge entry and held through the ACK phase.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      vector <= VEC_BASE;
    end else if (ack_entry_c) begin
      vector <= VEC_BASE | {4'h0, sel_c.idx, 1'b0};
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mask_q    <= '1;
      pending_q <= '0;
    end else begin
      if (mask_we) mask_q <= mask_din;
      pending_q <= pend_nxt_c;
    end
  end

endmodule
